// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: FSM encoding, stage index width
// and the default watchdog limit.
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } seq_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 200000;
    localparam int unsigned IDX_W           = 2;

endpackage

// File: rtl/layer_sequencer_stage_timer.sv
// Per-stage watchdog: counts enabled cycles since the last clear and flags
// expiry once the stage has been waiting TIMEOUT-1 cycles.
module stage_timer
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned W_CNT   = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count holds cycles already elapsed, so the current cycle is the
    // (cnt_q+1)-th; expiry fires when that reaches TIMEOUT-1.
    localparam int unsigned LIMIT = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

    logic [W_CNT-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q >= W_CNT'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired && (cnt_q != '1)) begin
            cnt_d = cnt_q + W_CNT'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences NUM_STAGES pipeline stages one after another, with a per-stage
// watchdog, abort handling and a saturating run-length counter.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int unsigned W_CNT      = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_stage,
    output logic [W_CNT-1:0]      run_cycles
);

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_go_q, stage_go_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [IDX_W-1:0]      err_stage_q, err_stage_d;
    logic [W_CNT-1:0]      run_cnt_q, run_cnt_d;
    logic [W_CNT-1:0]      run_cycles_q, run_cycles_d;

    logic                  timer_expired;
    logic                  ready_hit;
    logic                  last_stage;
    logic [W_CNT-1:0]      run_inc;

    stage_timer #(
        .TIMEOUT (TIMEOUT),
        .W_CNT   (W_CNT)
    ) u_stage_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == S_LAUNCH),
        .enable  (state_q == S_WAIT),
        .expired (timer_expired)
    );

    assign ready_hit  = |(stage_ready & (NUM_STAGES'(1) << idx_q));
    assign last_stage = (idx_q == IDX_W'(NUM_STAGES - 1));
    assign run_inc    = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + W_CNT'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        error_d      = error_q;
        err_stage_d  = err_stage_q;
        run_cnt_d    = run_cnt_q;
        run_cycles_d = run_cycles_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (go) begin
                    idx_d       = '0;
                    error_d     = 1'b0;
                    err_stage_d = '0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // Priority: abort, then ready, then watchdog expiry.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ready_hit) begin
                    if (last_stage) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LAUNCH;
                    end
                end else if (timer_expired) begin
                    error_d     = 1'b1;
                    err_stage_d = idx_q;
                    state_d     = S_ERR;
                end
            end
            S_DONE: begin
                run_cycles_d = run_inc;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_LAUNCH) && (idx_q == '0)) begin
            run_cnt_d = '0;
        end else if ((state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_DONE)) begin
            run_cnt_d = run_inc;
        end

        // Outputs are registered from the next state so they align with it.
        stage_go_d = (state_d == S_LAUNCH) ? (NUM_STAGES'(1) << idx_d) : '0;
        busy_d     = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_DONE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            stage_go_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_stage_q  <= '0;
            run_cnt_q    <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            stage_go_q   <= stage_go_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_stage_q  <= err_stage_d;
            run_cnt_q    <= run_cnt_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign stage_go   = stage_go_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_stage  = err_stage_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: expected stage_go/done events are
// queued with their cycle numbers and matched by a negedge monitor.
module tb_layer_sequencer;

    typedef struct {
        int kind;   // 0 = stage_go, 1 = done
        int stage;
        int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  stage_ready = '0;
    logic [2:0]  stage_go;
    logic        busy, done, error;
    logic [1:0]  err_stage;
    logic [19:0] run_cycles;

    logic        go2 = 1'b0;
    logic        abort2 = 1'b0;
    logic [2:0]  stage_ready2 = '0;
    logic [2:0]  stage_go2;
    logic        busy2, done2, error2;
    logic [1:0]  err_stage2;
    logic [5:0]  run_cycles2;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    ev_t  exp_q[$];

    layer_sequencer #(.NUM_STAGES(3), .TIMEOUT(100), .W_CNT(20)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .stage_ready(stage_ready),
        .stage_go(stage_go), .busy(busy), .done(done), .error(error),
        .err_stage(err_stage), .run_cycles(run_cycles)
    );

    layer_sequencer #(.NUM_STAGES(3), .TIMEOUT(50), .W_CNT(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .go(go2), .abort(abort2), .stage_ready(stage_ready2),
        .stage_go(stage_go2), .busy(busy2), .done(done2), .error(error2),
        .err_stage(err_stage2), .run_cycles(run_cycles2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every stage_go or done pulse must match the head of the queue.
    always @(negedge clk) begin
        ev_t e;
        int  sidx;
        if (stage_go !== 3'b000) begin
            sidx = 0;
            for (int i = 0; i < 3; i++) if (stage_go[i]) sidx = i;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_stage_go: got stage_go=%b at cycle %0d, want no pulse", stage_go, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind !== 0 || e.stage !== sidx || e.cyc !== cyc || $countones(stage_go) != 1)
                    $display("FAIL stage_go_event: got stage_go=%b at cycle %0d, want stage %0d (kind %0d) at cycle %0d",
                             stage_go, cyc, e.stage, e.kind, e.cyc);
                else passes++;
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind !== 1 || e.cyc !== cyc)
                    $display("FAIL done_event: got done at cycle %0d, want kind %0d stage %0d at cycle %0d",
                             cyc, e.kind, e.stage, e.cyc);
                else passes++;
            end
        end
    end

    task automatic push_ev(input int kind, input int stage, input int c);
        ev_t e;
        e.kind = kind; e.stage = stage; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; stage_ready = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({stage_go, busy, done, error, err_stage} !== 8'd0)
            $display("FAIL reset_outputs: got go=%b busy=%b done=%b err=%b es=%0d, want all 0",
                     stage_go, busy, done, error, err_stage);
        else passes++;
        checks++;
        if (run_cycles !== 20'd0) $display("FAIL reset_run_cycles: got %0d want 0", run_cycles);
        else passes++;
        checks++;
        if ({stage_go2, busy2, done2, error2, err_stage2, run_cycles2} !== 14'd0)
            $display("FAIL reset_sat_outputs: got %b want 0", {stage_go2, busy2, done2, error2, err_stage2, run_cycles2});
        else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal();
        int base;
        @(negedge clk); base = cyc;
        push_ev(0, 0, base + 1); push_ev(0, 1, base + 12);
        push_ev(0, 2, base + 23); push_ev(1, 0, base + 34);
        for (int k = 0; k <= 36; k++) begin
            if (k > 0) @(negedge clk);
            go = (k == 0);
            stage_ready = (k == 11) ? 3'b001 : (k == 22) ? 3'b010 : (k == 33) ? 3'b100 : 3'b000;
            if (k == 5) begin
                checks++;
                if (busy !== 1'b1) $display("FAIL nominal_busy: got %b want 1", busy);
                else passes++;
            end
        end
        go = 1'b0; stage_ready = '0;
        checks++;
        if (run_cycles !== 20'd33) $display("FAIL nominal_run_cycles: got %0d want 33", run_cycles);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL nominal_idle_busy: got %b want 0", busy);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL nominal_missing: got %0d pending events want 0", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_timeout();
        int base;
        @(negedge clk); base = cyc;
        push_ev(0, 0, base + 1); push_ev(0, 1, base + 12); push_ev(0, 0, base + 126);
        for (int k = 0; k <= 133; k++) begin
            if (k > 0) @(negedge clk);
            go = (k == 0) || (k == 125);
            abort = (k == 130);
            stage_ready = (k == 11) ? 3'b001 : 3'b000;
            if (k == 111) begin
                checks++;
                if (error !== 1'b0) $display("FAIL timeout_early: got error=%b want 0 at 99 cycles", error);
                else passes++;
            end
            if (k == 112) begin
                checks++;
                if (error !== 1'b1 || err_stage !== 2'd1 || busy !== 1'b0)
                    $display("FAIL timeout_flag: got error=%b err_stage=%0d busy=%b want 1/1/0", error, err_stage, busy);
                else passes++;
            end
            if (k == 120) begin
                checks++;
                if (error !== 1'b1) $display("FAIL timeout_sticky: got error=%b want 1", error);
                else passes++;
            end
            if (k == 126) begin
                checks++;
                if (error !== 1'b0 || busy !== 1'b1)
                    $display("FAIL timeout_restart: got error=%b busy=%b want 0/1", error, busy);
                else passes++;
            end
        end
        go = 1'b0; abort = 1'b0; stage_ready = '0;
        checks++;
        if (run_cycles !== 20'd33 || busy !== 1'b0)
            $display("FAIL timeout_run_cycles: got %0d busy=%b want 33/0", run_cycles, busy);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL timeout_missing: got %0d pending events want 0", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_abort();
        int base;
        @(negedge clk); base = cyc;
        push_ev(0, 0, base + 1); push_ev(0, 1, base + 12);
        for (int k = 0; k <= 35; k++) begin
            if (k > 0) @(negedge clk);
            go = (k == 0);
            abort = (k == 17);
            stage_ready = (k == 11) ? 3'b001 : (k == 20) ? 3'b010 : (k == 30) ? 3'b100 : 3'b000;
            if (k == 17) begin
                checks++;
                if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy);
                else passes++;
            end
            if (k == 18) begin
                checks++;
                if (busy !== 1'b0 || error !== 1'b0)
                    $display("FAIL abort_exit: got busy=%b error=%b want 0/0", busy, error);
                else passes++;
            end
        end
        go = 1'b0; abort = 1'b0; stage_ready = '0;
        checks++;
        if (run_cycles !== 20'd33) $display("FAIL abort_run_cycles: got %0d want 33", run_cycles);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL abort_missing: got %0d pending events want 0", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_ignored();
        int base;
        @(negedge clk); base = cyc;
        push_ev(0, 0, base + 1); push_ev(0, 1, base + 5);
        push_ev(0, 2, base + 10); push_ev(1, 0, base + 21);
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) @(negedge clk);
            go = (k == 0) || (k == 3) || (k == 12) || (k == 21);
            case (k)
                2:       stage_ready = 3'b100;
                4:       stage_ready = 3'b001;
                7:       stage_ready = 3'b001;
                9:       stage_ready = 3'b010;
                20:      stage_ready = 3'b100;
                23:      stage_ready = 3'b111;
                default: stage_ready = 3'b000;
            endcase
        end
        go = 1'b0; stage_ready = '0;
        checks++;
        if (run_cycles !== 20'd20) $display("FAIL ignored_run_cycles: got %0d want 20", run_cycles);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL ignored_missing: got %0d pending events want 0", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_race();
        int base;
        @(negedge clk); base = cyc;
        push_ev(0, 0, base + 1); push_ev(0, 1, base + 12); push_ev(0, 2, base + 112);
        for (int k = 0; k <= 123; k++) begin
            if (k > 0) @(negedge clk);
            go = (k == 0);
            abort = (k == 120);
            stage_ready = (k == 11) ? 3'b001 : (k == 111) ? 3'b010 : (k == 120) ? 3'b100 : 3'b000;
            if (k == 112) begin
                checks++;
                if (error !== 1'b0 || busy !== 1'b1)
                    $display("FAIL race_ready_wins: got error=%b busy=%b want 0/1", error, busy);
                else passes++;
            end
            if (k == 121) begin
                checks++;
                if (busy !== 1'b0 || error !== 1'b0)
                    $display("FAIL race_abort_wins: got busy=%b error=%b want 0/0", busy, error);
                else passes++;
            end
        end
        go = 1'b0; abort = 1'b0; stage_ready = '0;
        checks++;
        if (run_cycles !== 20'd20) $display("FAIL race_run_cycles: got %0d want 20", run_cycles);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL race_missing: got %0d pending events want 0", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int base;
        @(negedge clk); base = cyc;
        push_ev(0, 0, base + 1); push_ev(0, 0, base + 10);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            go = (k == 0) || (k == 9);
            abort = (k == 14);
            if (k == 5) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (busy !== 1'b0 || run_cycles !== 20'd0 || stage_go !== 3'b000 || done !== 1'b0)
                    $display("FAIL reset_mid_async: got busy=%b run=%0d go=%b done=%b want all 0",
                             busy, run_cycles, stage_go, done);
                else passes++;
            end
            if (k == 7) rst_n = 1'b1;
            if (k == 10) begin
                checks++;
                if (busy !== 1'b1) $display("FAIL reset_mid_restart: got busy=%b want 1", busy);
                else passes++;
            end
        end
        go = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_mid_abort: got busy=%b want 0", busy);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL reset_mid_missing: got %0d pending events want 0", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_saturate();
        for (int k = 0; k <= 81; k++) begin
            if (k > 0) @(negedge clk);
            go2 = (k == 0);
            stage_ready2 = (k == 26) ? 3'b001 : (k == 52) ? 3'b010 : (k == 78) ? 3'b100 : 3'b000;
            if (k == 27) begin
                checks++;
                if (stage_go2 !== 3'b010) $display("FAIL sat_stage_go1: got %b want 010", stage_go2);
                else passes++;
            end
            if (k == 79) begin
                checks++;
                if (done2 !== 1'b1) $display("FAIL sat_done: got %b want 1", done2);
                else passes++;
            end
        end
        go2 = 1'b0; stage_ready2 = '0;
        checks++;
        if (run_cycles2 !== 6'd63) $display("FAIL sat_run_cycles: got %0d want 63", run_cycles2);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_abort();
        test_ignored();
        test_race();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
